serial_word_deserializer: RTL and testbench

//  Downstream stage of the dual-edge XOR/select flop block. Samples that block's 1-bit q stream on posedge clk,

---
 rtl/deser_pkg.sv | 19 +
 rtl/deser_fifo.sv | 54 +++++
 rtl/serial_word_deserializer.sv | 132 +++++++++++++
 tb/tb_serial_word_deserializer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and width helpers for the serial word deserializer.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    // Bit counter must be able to hold WIDTH itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/deser_fifo.sv
// Synchronous first-word-fall-through FIFO; overflow policy belongs to the caller.
module deser_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] lvl_q;
    logic          do_push, do_pop;

    assign empty_o = (lvl_q == '0);
    assign full_o  = (lvl_q == LW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is only legal when a pop frees a slot on the same edge.
    assign do_push = push_i && (!full_o || do_pop);
    assign level_o = lvl_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   lvl_q <= lvl_q + 1'b1;
                2'b01:   lvl_q <= lvl_q - 1'b1;
                default: lvl_q <= lvl_q;
            endcase
        end
    end

endmodule

// File: rtl/serial_word_deserializer.sv
// Frames a 1-bit stream into WIDTH-bit words and buffers them in a FIFO.
// Optional even-parity bit per word when DESER_PARITY_EN is defined.
module serial_word_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bit_in,
    input  logic                       bit_vld,
    input  logic                       frame_start,
    input  logic                       clr_ovf,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_perr,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow
);
    localparam int CW = cnt_w(WIDTH);
`ifdef DESER_PARITY_EN
    localparam int FW = WIDTH + 1;
`else
    localparam int FW = WIDTH;
`endif

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic             ovf_q;

    logic [WIDTH-1:0] sr_d;
    logic             last_bit;
    logic             push;
    logic [FW-1:0]    push_data;
    logic [FW-1:0]    head;
    logic             fifo_full, fifo_empty;
    logic             drop;

    assign sr_d     = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], bit_in} : {bit_in, sr_q[WIDTH-1:1]};
    assign last_bit = (state_q == SHIFT) && bit_vld && !frame_start && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        push      = 1'b0;
        push_data = '0;
`ifdef DESER_PARITY_EN
        if ((state_q == PARITY) && bit_vld && !frame_start) begin
            push      = 1'b1;
            push_data = {(^sr_q) ^ bit_in, sr_q};
        end
`else
        if (last_bit) begin
            push      = 1'b1;
            push_data = sr_d;
        end
`endif
    end

    // A completed word with no free slot (and no pop this edge) is lost.
    assign drop = push && fifo_full && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (drop)         ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;

            if (bit_vld) begin
                if (frame_start) begin
                    state_q <= SHIFT;
                    cnt_q   <= CW'(1);
                    sr_q    <= sr_d;
                end else begin
                    case (state_q)
                        SHIFT: begin
                            sr_q <= sr_d;
                            if (last_bit) begin
                                cnt_q <= '0;
`ifdef DESER_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= IDLE;
`endif
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        PARITY: begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                        default: begin
                            state_q <= state_q;
                        end
                    endcase
                end
            end
        end
    end

    deser_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (out_ready),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    assign out_data  = head[WIDTH-1:0];
    assign out_valid = !fifo_empty;
    assign overflow  = ovf_q;
`ifdef DESER_PARITY_EN
    assign out_perr  = head[WIDTH];
`else
    assign out_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench for serial_word_deserializer (WIDTH=8, DEPTH=4, MSB_FIRST=1).
module tb_serial_word_deserializer;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         bit_in = 1'b0, bit_vld = 1'b0, frame_start = 1'b0, clr_ovf = 1'b0, out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid, out_perr, overflow;
    logic [2:0]   fifo_level;

    serial_word_deserializer #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld),
        .frame_start(frame_start), .clr_ovf(clr_ovf), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_perr(out_perr),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int max_lvl = 0;

    // Reference model: received bits as a list, FIFO as a queue of {perr, word}.
    logic [W:0] mq[$];
    bit         mbits[$];
    bit         m_coll = 0;
    bit         m_par  = 0;
    bit         m_ovf  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] bits_to_word();
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) w[W-1-i] = mbits[i];
        return w;
    endfunction

    function automatic bit even_par(input logic [W-1:0] w);
        return bit'($countones(w) % 2);
    endfunction

    task automatic model_clear();
        mq.delete();
        mbits.delete();
        m_coll = 0;
        m_par  = 0;
        m_ovf  = 0;
    endtask

    task automatic model_edge();
        bit         pop, push, dropped;
        logic [W:0] w;
        int         s;
        pop = (mq.size() > 0) && out_ready;
        push = 0;
        w = '0;
        if (bit_vld) begin
            if (frame_start) begin
                mbits.delete();
                mbits.push_back(bit_in);
                m_coll = 1;
                m_par  = 0;
            end else if (m_par) begin
                push   = 1;
                w      = {even_par(bits_to_word()) ^ bit_in, bits_to_word()};
                m_par  = 0;
            end else if (m_coll) begin
                mbits.push_back(bit_in);
                if (mbits.size() == W) begin
                    m_coll = 0;
`ifdef DESER_PARITY_EN
                    m_par = 1;
`else
                    push = 1;
                    w    = {1'b0, bits_to_word()};
`endif
                end
            end
        end
        s = mq.size();
        dropped = push && (s == D) && !pop;
        if (pop) void'(mq.pop_front());
        if (push && !dropped) mq.push_back(w);
        if (dropped) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endtask

    task automatic check_outputs();
        check("valid", 32'(out_valid), 32'(mq.size() > 0));
        check("level", 32'(fifo_level), 32'(mq.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() > 0) begin
            check("data", 32'(out_data), 32'(mq[0][W-1:0]));
            check("perr", 32'(out_perr), 32'(mq[0][W]));
        end
    endtask

    task automatic step(input bit v, input bit fs, input bit b, input bit rdy, input bit clr);
        bit_vld = v; frame_start = fs; bit_in = b; out_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    endtask

    // Sends one frame; rdy_last applies to the final cycle of the frame.
    task automatic send_word(input logic [W-1:0] word, input bit par, input bit rdy, input bit rdy_last);
        int nb;
`ifdef DESER_PARITY_EN
        nb = W + 1;
`else
        nb = W;
`endif
        for (int i = 0; i < nb; i++) begin
            bit b;
            b = (i < W) ? word[W-1-i] : par;
            step(1, i == 0, b, (i == nb - 1) ? rdy_last : rdy, 0);
        end
    endtask

    typedef struct {
        bit           vld, fs, b, rdy;
        bit           ev;
        logic [W-1:0] ed;
    } vec_t;
    vec_t tbl[$];

    initial begin
        logic [W-1:0] a5;
        a5 = 8'hA5;
        for (int i = 0; i < W; i++) begin
`ifdef DESER_PARITY_EN
            tbl.push_back('{1, i == 0, a5[W-1-i], 1, 0, 8'h00});
`else
            tbl.push_back('{1, i == 0, a5[W-1-i], 1, i == W - 1, 8'hA5});
`endif
        end
`ifdef DESER_PARITY_EN
        tbl.push_back('{1, 0, 0, 1, 1, 8'hA5});
`endif
        tbl.push_back('{0, 0, 0, 1, 0, 8'h00});
        tbl.push_back('{0, 0, 0, 1, 0, 8'h00});

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_perr", 32'(out_perr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();

        // Single word, table-driven with fixed expectations
        foreach (tbl[k]) begin
            step(tbl[k].vld, tbl[k].fs, tbl[k].b, tbl[k].rdy, 0);
            check("tbl_valid", 32'(out_valid), 32'(tbl[k].ev));
            if (tbl[k].ev) check("tbl_data", 32'(out_data), 32'(tbl[k].ed));
        end

        // Abort a partial frame
        max_lvl = 0;
        step(1, 1, 1, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        send_word(8'h3C, even_par(8'h3C), 1, 1);
        check("abort_valid", 32'(out_valid), 1);
        check("abort_data", 32'(out_data), 32'h3C);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("abort_maxlvl", 32'(max_lvl <= 1), 1);
        check("abort_empty", 32'(out_valid), 0);

        // Overflow with stalled consumer
        for (int k = 1; k <= 5; k++) send_word(W'(k), even_par(W'(k)), 0, 0);
        check("ovf_level", 32'(fifo_level), 4);
        check("ovf_flag", 32'(overflow), 1);
        for (int k = 1; k <= 4; k++) begin
            check("ovf_order", 32'(out_data), 32'(k));
            step(0, 0, 0, 1, 0);
        end
        check("ovf_drained", 32'(out_valid), 0);
        check("ovf_sticky", 32'(overflow), 1);
        step(0, 0, 0, 0, 1);
        check("ovf_clr", 32'(overflow), 0);

        // Full FIFO: push coincident with pop
        for (int k = 0; k < 4; k++) send_word(W'(8'h11 + k), even_par(W'(8'h11 + k)), 0, 0);
        send_word(8'h55, even_par(8'h55), 0, 1);
        check("fullpp_level", 32'(fifo_level), 4);
        check("fullpp_ovf", 32'(overflow), 0);
        for (int k = 0; k < 4; k++) begin
            check("fullpp_order", 32'(out_data), (k < 3) ? 32'h12 + 32'(k) : 32'h55);
            step(0, 0, 0, 1, 0);
        end

        // Asynchronous reset mid-frame with two words buffered
        send_word(8'h81, even_par(8'h81), 0, 0);
        send_word(8'h42, even_par(8'h42), 0, 0);
        for (int i = 0; i < 5; i++) step(1, i == 0, 1, 0, 0);
        check("prerst_level", 32'(fifo_level), 2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_data", 32'(out_data), 0);
        check("midrst_level", 32'(fifo_level), 0);
        check("midrst_ovf", 32'(overflow), 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'hFF, even_par(8'hFF), 1, 1);
        check("postrst_valid", 32'(out_valid), 1);
        check("postrst_data", 32'(out_data), 32'hFF);
        step(0, 0, 0, 1, 0);

        // Parity flag
`ifdef DESER_PARITY_EN
        send_word(8'hA5, 1'b0, 1, 1);
        check("par_ok", 32'(out_perr), 0);
        step(0, 0, 0, 1, 0);
        send_word(8'hA5, 1'b1, 1, 1);
        check("par_err", 32'(out_perr), 1);
        step(0, 0, 0, 1, 0);
`else
        send_word(8'hA5, 1'b1, 1, 1);
        check("noparity_perr", 32'(out_perr), 0);
        check("noparity_data", 32'(out_data), 32'hA5);
        step(0, 0, 0, 1, 0);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 8,
                 bit'($urandom_range(0, 1)), $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
